// File: rtl/div_ratio_meas.sv
// Divide-ratio meter: recovers period, high time and a windowed
// period sum of a divided signal, counted in source clock cycles.
module div_ratio_meas #(
    parameter int CNT_W    = 16,
    parameter int AVG_LOG2 = 3,
    parameter int SUM_W    = CNT_W + AVG_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic [SUM_W-1:0] sum,
    output logic             sum_vld,
    output logic             ovf
);

    localparam int KW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [KW-1:0]    K_LAST  = KW'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        S_IDLE,
        S_MEAS
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_d1;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_hlat;
    logic             r_fall_seen;
    logic [SUM_W-1:0] r_acc;
    logic [KW-1:0]    r_k;

    logic w_rise;
    logic w_fall;
    logic w_start;
    logic w_close;
    logic w_sat;
    logic w_win_done;

    assign w_rise = div_in & ~r_d1;
    assign w_fall = ~div_in & r_d1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_MEAS;
            S_MEAS: if (w_sat)   w_state_nxt = S_IDLE;
        endcase
        if (!en) w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_start    = en && (r_state == S_IDLE) && w_rise;
        w_close    = en && (r_state == S_MEAS) && w_rise;
        w_sat      = en && (r_state == S_MEAS) && !w_rise
                     && (r_cnt == CNT_MAX);
        w_win_done = w_close && (r_k == K_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d1        <= 1'b0;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_hlat      <= '0;
            r_fall_seen <= 1'b0;
            r_acc       <= '0;
            r_k         <= '0;
            period      <= '0;
            high_time   <= '0;
            period_vld  <= 1'b0;
            sum         <= '0;
            sum_vld     <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            r_d1       <= div_in;
            period_vld <= 1'b0;
            sum_vld    <= 1'b0;
            if (!en) begin
                r_cnt       <= '0;
                r_hcnt      <= '0;
                r_hlat      <= '0;
                r_fall_seen <= 1'b0;
                r_acc       <= '0;
                r_k         <= '0;
                ovf         <= 1'b0;
            end else if (w_start) begin
                r_cnt       <= CNT_ONE;
                r_hcnt      <= CNT_ONE;
                r_fall_seen <= 1'b0;
                r_acc       <= '0;
                r_k         <= '0;
            end else if (w_close) begin
                period      <= r_cnt;
                // Without a seen fall the signal never dropped; report hcnt
                high_time   <= r_fall_seen ? r_hlat : r_hcnt;
                period_vld  <= 1'b1;
                r_cnt       <= CNT_ONE;
                r_hcnt      <= CNT_ONE;
                r_fall_seen <= 1'b0;
                if (w_win_done) begin
                    sum     <= r_acc + SUM_W'(r_cnt);
                    sum_vld <= 1'b1;
                    r_acc   <= '0;
                    r_k     <= '0;
                end else begin
                    r_acc <= r_acc + SUM_W'(r_cnt);
                    r_k   <= r_k + KW'(1);
                end
            end else if (w_sat) begin
                ovf    <= 1'b1;
                r_cnt  <= '0;
                r_hcnt <= '0;
                r_acc  <= '0;
                r_k    <= '0;
            end else if (r_state == S_MEAS) begin
                r_cnt <= r_cnt + CNT_ONE;
                if (div_in) r_hcnt <= r_hcnt + CNT_ONE;
                if (w_fall) begin
                    r_hlat      <= r_hcnt;
                    r_fall_seen <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_ratio_meas.sv
// Directed bench for div_ratio_meas: div2, div5, dual-modulus,
// overflow, enable drop and mid-run reset.
module tb_div_ratio_meas;

    localparam int CNT_W    = 4;
    localparam int AVG_LOG2 = 3;
    localparam int SUM_W    = CNT_W + AVG_LOG2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             div_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_vld;
    logic [SUM_W-1:0] sum;
    logic             sum_vld;
    logic             ovf;

    int n_checks = 0;
    int n_errors = 0;
    int n_spur   = 0;

    div_ratio_meas #(
        .CNT_W   (CNT_W),
        .AVG_LOG2(AVG_LOG2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_in    (div_in),
        .period    (period),
        .high_time (high_time),
        .period_vld(period_vld),
        .sum       (sum),
        .sum_vld   (sum_vld),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v);
        div_in = v;
        @(posedge clk);
        #1;
    endtask

    // One div_in period; the rise cycle closes the previous period
    task automatic per(input string tag, input int hi, input int lo,
                       input logic xv, input int xp, input int xh,
                       input logic xs, input int xsum);
        cyc(1'b1);
        check({tag, ".pv"}, 32'(period_vld), 32'(xv));
        if (xv) begin
            check({tag, ".per"}, 32'(period), xp);
            check({tag, ".hi"}, 32'(high_time), xh);
        end
        check({tag, ".sv"}, 32'(sum_vld), 32'(xs));
        if (xs) check({tag, ".sum"}, 32'(sum), xsum);
        for (int i = 1; i < hi + lo; i++) begin
            cyc(i < hi);
            if (period_vld || sum_vld) n_spur++;
        end
    endtask

    task automatic en_off();
        en = 1'b0;
        cyc(1'b0);
        if (period_vld || sum_vld) n_spur++;
        cyc(1'b0);
        if (period_vld || sum_vld) n_spur++;
        check("enoff.ovf", 32'(ovf), 0);
        en = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        div_in = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        check("rst.per", 32'(period), 0);
        check("rst.hi", 32'(high_time), 0);
        check("rst.pv", 32'(period_vld), 0);
        check("rst.sum", 32'(sum), 0);
        check("rst.sv", 32'(sum_vld), 0);
        check("rst.ovf", 32'(ovf), 0);
        rst = 1'b0;
        en  = 1'b1;

        // div2
        per("d2.first", 1, 1, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 1; i <= 16; i++)
            per("d2", 1, 1, 1'b1, 2, 1, (i % 8 == 0), 16);
        check("d2.ovf", 32'(ovf), 0);

        // div5, high 2 / low 3
        en_off();
        check("hold.per", 32'(period), 2);
        check("hold.hi", 32'(high_time), 1);
        check("hold.sum", 32'(sum), 16);
        per("d5.first", 2, 3, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 1; i <= 16; i++)
            per("d5", 2, 3, 1'b1, 5, 2, (i % 8 == 0), 40);

        // dual modulus 4,5,4,5...
        en_off();
        per("dm.first", 2, 2, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 1; i <= 16; i++)
            per("dm", 2, (i % 2 == 0) ? 2 : 3, 1'b1,
                (i % 2 == 0) ? 5 : 4, 2, (i % 8 == 0), 36);

        // partial window then enable drop
        en_off();
        per("pw.first", 2, 3, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 1; i <= 5; i++)
            per("pw", 2, 3, 1'b1, 5, 2, 1'b0, 0);
        en_off();
        check("pw.hold.per", 32'(period), 5);
        check("pw.hold.sum", 32'(sum), 36);
        per("pw.re", 2, 3, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 1; i <= 8; i++)
            per("pw2", 2, 3, 1'b1, 5, 2, (i == 8), 40);

        // overflow with div_in stuck low
        en_off();
        cyc(1'b1);
        check("ov.first.pv", 32'(period_vld), 0);
        for (int i = 1; i <= 14; i++) begin
            cyc(1'b0);
            if (period_vld || sum_vld) n_spur++;
        end
        check("ov.pre", 32'(ovf), 0);
        cyc(1'b0);
        check("ov.set", 32'(ovf), 1);
        check("ov.pv", 32'(period_vld), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            if (period_vld || sum_vld) n_spur++;
        end
        per("ov.resume", 1, 1, 1'b0, 0, 0, 1'b0, 0);
        check("ov.sticky1", 32'(ovf), 1);
        per("ov.run", 1, 1, 1'b1, 2, 1, 1'b0, 0);
        check("ov.sticky2", 32'(ovf), 1);

        // synchronous reset mid-measurement
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        check("mr.per", 32'(period), 0);
        check("mr.hi", 32'(high_time), 0);
        check("mr.pv", 32'(period_vld), 0);
        check("mr.sum", 32'(sum), 0);
        check("mr.sv", 32'(sum_vld), 0);
        check("mr.ovf", 32'(ovf), 0);
        per("mr.first", 1, 1, 1'b0, 0, 0, 1'b0, 0);
        per("mr.run", 1, 1, 1'b1, 2, 1, 1'b0, 0);

        check("spurious.vld", n_spur, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
